// File: rtl/ex_pkg.sv
// Shared encodings and types for the execute stage.
package ex_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_MULT = 6'b011000;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_MUL, ALU_NOP
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE, ST_MUL, ST_DONE
  } state_e;

  // Width-independent part of the EX/MEM bundle.
  typedef struct packed {
    logic       valid;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       flush;
    logic [4:0] write_reg;
  } exm_ctrl_t;

  // Map alu_op/funct onto a single ALU operation.
  function automatic alu_ctrl_e decode_alu(input logic [1:0] alu_op, input logic [5:0] funct);
    alu_ctrl_e ctrl;
    ctrl = ALU_NOP;
    case (alu_op)
      ALUOP_ADD: ctrl = ALU_ADD;
      ALUOP_SUB: ctrl = ALU_SUB;
      ALUOP_OR:  ctrl = ALU_OR;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD:  ctrl = ALU_ADD;
          FUNCT_SUB:  ctrl = ALU_SUB;
          FUNCT_AND:  ctrl = ALU_AND;
          FUNCT_OR:   ctrl = ALU_OR;
          FUNCT_SLT:  ctrl = ALU_SLT;
          FUNCT_SLL:  ctrl = ALU_SLL;
          FUNCT_MULT: ctrl = ALU_MUL;
          default:    ctrl = ALU_NOP;
        endcase
      end
      default: ctrl = ALU_NOP;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/ex_mult_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, low XLEN bits kept.
module ex_mult_seq
  import ex_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int MUL_CYCLES = XLEN_DEFAULT
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CNT_W = $clog2(MUL_CYCLES);

  logic             run_q, run_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [XLEN-1:0]  acc_q, acc_d;

  // done marks the cycle whose edge performs the final iteration.
  assign done    = run_q & (count_q == CNT_W'(MUL_CYCLES - 1));
  assign product = acc_q;

  // Next iteration: add shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    run_d    = run_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start) begin
      run_d    = 1'b1;
      count_d  = '0;
      mcand_d  = op_a;
      mplier_d = op_b;
      acc_d    = '0;
    end else if (run_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CNT_W'(1);
      if (done) begin
        run_d   = 1'b0;
        count_d = '0;
      end
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_q    <= 1'b0;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      run_q    <= run_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch/jump resolution, MULT sequencing and EX/MEM registers.
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int MUL_CYCLES = XLEN_DEFAULT
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            ex_valid,
  input  logic            branch,
  input  logic            jump,
  input  logic            alu_src,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            reg_write,
  input  logic            reg_dst,
  input  logic            mem_to_reg,
  input  logic [1:0]      alu_op,
  input  logic [XLEN-1:0] npc,
  input  logic [XLEN-1:0] readdata1,
  input  logic [XLEN-1:0] readdata2,
  input  logic [XLEN-1:0] sigext,
  input  logic [4:0]      rt,
  input  logic [4:0]      rd,
  input  logic            mem_stall,
  output logic            ex_busy,
  output logic            exm_valid,
  output logic            exm_mem_read,
  output logic            exm_mem_write,
  output logic            exm_reg_write,
  output logic            exm_mem_to_reg,
  output logic [XLEN-1:0] exm_alu_result,
  output logic [XLEN-1:0] exm_write_data,
  output logic [4:0]      exm_write_reg,
  output logic            exm_flush,
  output logic [XLEN-1:0] exm_target
);

  state_e          state_q, state_d;
  exm_ctrl_t       exm_ctrl_q, exm_ctrl_d;
  logic [XLEN-1:0] exm_result_q, exm_result_d;
  logic [XLEN-1:0] exm_wdata_q, exm_wdata_d;
  logic [XLEN-1:0] exm_target_q, exm_target_d;
  exm_ctrl_t       pend_ctrl_q, pend_ctrl_d;
  logic [XLEN-1:0] pend_wdata_q, pend_wdata_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;

  alu_ctrl_e       alu_ctrl;
  logic [XLEN-1:0] op_b, alu_res, target;
  logic            taken, do_jump;
  exm_ctrl_t       cur_ctrl;
  logic            mult_start, mult_done;
  logic [XLEN-1:0] mult_product;

  ex_mult_seq #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) u_mult (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (mult_start),
    .op_a    (readdata1),
    .op_b    (op_b),
    .done    (mult_done),
    .product (mult_product)
  );

  // Decode, ALU, redirect and the control bundle for the current instruction.
  always_comb begin
    op_b     = alu_src ? sigext : readdata2;
    alu_ctrl = decode_alu(alu_op, sigext[5:0]);
    case (alu_ctrl)
      ALU_ADD: alu_res = readdata1 + op_b;
      ALU_SUB: alu_res = readdata1 - op_b;
      ALU_AND: alu_res = readdata1 & op_b;
      ALU_OR:  alu_res = readdata1 | op_b;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(readdata1) < $signed(op_b))};
      ALU_SLL: alu_res = op_b << sigext[10:6];
      default: alu_res = '0;
    endcase
    taken   = branch & ex_valid & (readdata1 == readdata2);
    do_jump = jump & ex_valid;
    if (jump) target = {npc[XLEN-1:28], sigext[25:0], 2'b00};
    else      target = npc + (sigext << 2);
    cur_ctrl.valid      = ex_valid;
    cur_ctrl.mem_read   = ex_valid & mem_read;
    cur_ctrl.mem_write  = ex_valid & mem_write;
    cur_ctrl.reg_write  = ex_valid & reg_write;
    cur_ctrl.mem_to_reg = ex_valid & mem_to_reg;
    cur_ctrl.flush      = taken | do_jump;
    cur_ctrl.write_reg  = reg_dst ? rd : rt;
  end

  // State machine and next values of the EX/MEM registers.
  always_comb begin
    state_d       = state_q;
    exm_ctrl_d    = exm_ctrl_q;
    exm_result_d  = exm_result_q;
    exm_wdata_d   = exm_wdata_q;
    exm_target_d  = exm_target_q;
    pend_ctrl_d   = pend_ctrl_q;
    pend_wdata_d  = pend_wdata_q;
    pend_target_d = pend_target_q;
    mult_start    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!mem_stall) begin
          if (ex_valid && alu_ctrl == ALU_MUL) begin
            mult_start    = 1'b1;
            pend_ctrl_d   = cur_ctrl;
            pend_wdata_d  = readdata2;
            pend_target_d = target;
            exm_ctrl_d    = '0;
            state_d       = ST_MUL;
          end else begin
            exm_ctrl_d   = cur_ctrl;
            exm_result_d = alu_res;
            exm_wdata_d  = readdata2;
            exm_target_d = target;
          end
        end
      end
      ST_MUL: begin
        if (mult_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!mem_stall) begin
          exm_ctrl_d   = pend_ctrl_q;
          exm_result_d = mult_product;
          exm_wdata_d  = pend_wdata_q;
          exm_target_d = pend_target_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, pending MULT bundle and EX/MEM registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      exm_ctrl_q    <= '0;
      exm_result_q  <= '0;
      exm_wdata_q   <= '0;
      exm_target_q  <= '0;
      pend_ctrl_q   <= '0;
      pend_wdata_q  <= '0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      exm_ctrl_q    <= exm_ctrl_d;
      exm_result_q  <= exm_result_d;
      exm_wdata_q   <= exm_wdata_d;
      exm_target_q  <= exm_target_d;
      pend_ctrl_q   <= pend_ctrl_d;
      pend_wdata_q  <= pend_wdata_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign ex_busy        = (state_q != ST_IDLE) | mem_stall;
  assign exm_valid      = exm_ctrl_q.valid;
  assign exm_mem_read   = exm_ctrl_q.mem_read;
  assign exm_mem_write  = exm_ctrl_q.mem_write;
  assign exm_reg_write  = exm_ctrl_q.reg_write;
  assign exm_mem_to_reg = exm_ctrl_q.mem_to_reg;
  assign exm_flush      = exm_ctrl_q.flush;
  assign exm_write_reg  = exm_ctrl_q.write_reg;
  assign exm_alu_result = exm_result_q;
  assign exm_write_data = exm_wdata_q;
  assign exm_target     = exm_target_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage with hand-computed expectations.
module tb_ex_stage;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        ex_valid, branch, jump, alu_src, mem_read, mem_write;
  logic        reg_write, reg_dst, mem_to_reg, mem_stall;
  logic [1:0]  alu_op;
  logic [31:0] npc, readdata1, readdata2, sigext;
  logic [4:0]  rt, rd;
  logic        ex_busy, exm_valid, exm_mem_read, exm_mem_write, exm_reg_write;
  logic        exm_mem_to_reg, exm_flush;
  logic [31:0] exm_alu_result, exm_write_data, exm_target;
  logic [4:0]  exm_write_reg;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  ex_stage dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ex_valid       (ex_valid),
    .branch         (branch),
    .jump           (jump),
    .alu_src        (alu_src),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .reg_write      (reg_write),
    .reg_dst        (reg_dst),
    .mem_to_reg     (mem_to_reg),
    .alu_op         (alu_op),
    .npc            (npc),
    .readdata1      (readdata1),
    .readdata2      (readdata2),
    .sigext         (sigext),
    .rt             (rt),
    .rd             (rd),
    .mem_stall      (mem_stall),
    .ex_busy        (ex_busy),
    .exm_valid      (exm_valid),
    .exm_mem_read   (exm_mem_read),
    .exm_mem_write  (exm_mem_write),
    .exm_reg_write  (exm_reg_write),
    .exm_mem_to_reg (exm_mem_to_reg),
    .exm_alu_result (exm_alu_result),
    .exm_write_data (exm_write_data),
    .exm_write_reg  (exm_write_reg),
    .exm_flush      (exm_flush),
    .exm_target     (exm_target)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearBundle();
    ex_valid = 0; branch = 0; jump = 0; alu_src = 0; mem_read = 0; mem_write = 0;
    reg_write = 0; reg_dst = 0; mem_to_reg = 0; mem_stall = 0; alu_op = 2'b00;
    npc = 0; readdata1 = 0; readdata2 = 0; sigext = 0; rt = 0; rd = 0;
  endtask

  // Valid instruction with the given ALU encoding and operands.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] imm,
                               input logic [31:0] a, input logic [31:0] b, input logic src);
    clearBundle();
    ex_valid = 1; alu_op = op; sigext = imm; readdata1 = a; readdata2 = b; alu_src = src;
  endtask

  initial begin
    clearBundle();
    #2 reset_n = 0;
    #1;
    checkOutput("reset_valid", 32'(exm_valid), 32'd0);
    checkOutput("reset_result", exm_alu_result, 32'd0);
    checkOutput("reset_target", exm_target, 32'd0);
    checkOutput("reset_flush", 32'(exm_flush), 32'd0);
    checkOutput("reset_busy", 32'(ex_busy), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1;

    $display("[TB] ALU operations");
    applyStimulus(2'b10, 32'h20, 32'd5, 32'd7, 1'b0);
    reg_dst = 1; reg_write = 1; rd = 5'd9; rt = 5'd3;
    tick();
    checkOutput("add_result", exm_alu_result, 32'd12);
    checkOutput("add_valid", 32'(exm_valid), 32'd1);
    checkOutput("add_wreg", 32'(exm_write_reg), 32'd9);
    checkOutput("add_regwrite", 32'(exm_reg_write), 32'd1);
    checkOutput("add_wdata", exm_write_data, 32'd7);
    checkOutput("add_flush", 32'(exm_flush), 32'd0);

    applyStimulus(2'b10, 32'h2A, 32'hFFFF_FFFF, 32'd1, 1'b0);
    tick();
    checkOutput("slt_signed", exm_alu_result, 32'd1);

    applyStimulus(2'b10, 32'h22, 32'd5, 32'd7, 1'b0);
    tick();
    checkOutput("sub_wrap", exm_alu_result, 32'hFFFF_FFFE);

    applyStimulus(2'b10, 32'h24, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
    tick();
    checkOutput("and", exm_alu_result, 32'h00F0_00F0);

    applyStimulus(2'b11, 32'h0000_0F00, 32'h0000_00F0, 32'd0, 1'b1);
    tick();
    checkOutput("or_imm", exm_alu_result, 32'h0000_0FF0);

    applyStimulus(2'b10, 32'h0000_0100, 32'd0, 32'd3, 1'b0);
    tick();
    checkOutput("sll", exm_alu_result, 32'h30);

    applyStimulus(2'b10, 32'h3F, 32'd5, 32'd7, 1'b0);
    tick();
    checkOutput("bad_funct", exm_alu_result, 32'd0);

    applyStimulus(2'b00, 32'hFFFF_FFFC, 32'd8, 32'd99, 1'b1);
    rt = 5'd4; rd = 5'd17; mem_read = 1; mem_to_reg = 1;
    tick();
    checkOutput("addi_result", exm_alu_result, 32'd4);
    checkOutput("addi_wreg", 32'(exm_write_reg), 32'd4);
    checkOutput("addi_memread", 32'(exm_mem_read), 32'd1);
    checkOutput("addi_memtoreg", 32'(exm_mem_to_reg), 32'd1);

    applyStimulus(2'b00, 32'd1, 32'd1, 32'd0, 1'b1);
    ex_valid = 0; reg_write = 1; mem_write = 1;
    tick();
    checkOutput("invalid_valid", 32'(exm_valid), 32'd0);
    checkOutput("invalid_regwrite", 32'(exm_reg_write), 32'd0);
    checkOutput("invalid_memwrite", 32'(exm_mem_write), 32'd0);

    $display("[TB] branch and jump");
    applyStimulus(2'b01, 32'd4, 32'd3, 32'd3, 1'b0);
    branch = 1; npc = 32'h100;
    tick();
    checkOutput("beq_taken_flush", 32'(exm_flush), 32'd1);
    checkOutput("beq_target", exm_target, 32'h110);
    readdata2 = 32'd4;
    tick();
    checkOutput("beq_not_taken", 32'(exm_flush), 32'd0);

    applyStimulus(2'b00, 32'd0, 32'd1, 32'd2, 1'b0);
    mem_stall = 1;
    #1;
    checkOutput("stall_busy", 32'(ex_busy), 32'd1);
    tick();
    checkOutput("stall_hold_result", exm_alu_result, 32'hFFFF_FFFF);
    checkOutput("stall_hold_target", exm_target, 32'h110);
    mem_stall = 0;

    applyStimulus(2'b00, 32'h40, 32'd0, 32'd0, 1'b0);
    jump = 1; npc = 32'hA000_0000;
    tick();
    checkOutput("jump_flush", 32'(exm_flush), 32'd1);
    checkOutput("jump_target", exm_target, 32'hA000_0100);

    applyStimulus(2'b00, 32'd4, 32'd3, 32'd3, 1'b0);
    jump = 1; branch = 1; npc = 32'h1000_0100;
    tick();
    checkOutput("jump_priority", exm_target, 32'h1000_0010);

    $display("[TB] multiply");
    applyStimulus(2'b10, 32'h18, 32'd7, 32'd6, 1'b0);
    reg_dst = 1; reg_write = 1; rd = 5'd10;
    #1;
    checkOutput("mult_busy_before", 32'(ex_busy), 32'd0);
    tick();
    clearBundle();
    readdata1 = 32'hDEAD_BEEF; readdata2 = 32'h1234_5678;
    for (int k = 0; k <= 32; k++) begin
      checkOutput($sformatf("mult_bubble_%0d", k), 32'(exm_valid), 32'd0);
      checkOutput($sformatf("mult_busy_%0d", k), 32'(ex_busy), 32'd1);
      if (k < 32) tick();
    end
    tick();
    checkOutput("mult_commit_valid", 32'(exm_valid), 32'd1);
    checkOutput("mult_product", exm_alu_result, 32'd42);
    checkOutput("mult_wreg", 32'(exm_write_reg), 32'd10);
    checkOutput("mult_wdata", exm_write_data, 32'd6);
    checkOutput("mult_busy_after", 32'(ex_busy), 32'd0);
    tick();
    checkOutput("mult_one_cycle", 32'(exm_valid), 32'd0);

    $display("[TB] multiply with stall in DONE");
    applyStimulus(2'b10, 32'h18, 32'd7, 32'd6, 1'b0);
    tick();
    clearBundle();
    repeat (32) tick();
    mem_stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("stall_done_valid_%0d", k), 32'(exm_valid), 32'd0);
      checkOutput($sformatf("stall_done_busy_%0d", k), 32'(ex_busy), 32'd1);
    end
    mem_stall = 0;
    #1;
    checkOutput("stall_done_busy_release", 32'(ex_busy), 32'd1);
    tick();
    checkOutput("stall_commit_valid", 32'(exm_valid), 32'd1);
    checkOutput("stall_commit_product", exm_alu_result, 32'd42);

    $display("[TB] reset mid-multiply");
    applyStimulus(2'b10, 32'h18, 32'd7, 32'd6, 1'b0);
    tick();
    clearBundle();
    repeat (10) tick();
    #3 reset_n = 0;
    #1;
    checkOutput("abort_result", exm_alu_result, 32'd0);
    checkOutput("abort_wdata", exm_write_data, 32'd0);
    checkOutput("abort_valid", 32'(exm_valid), 32'd0);
    checkOutput("abort_busy", 32'(ex_busy), 32'd0);
    #2 reset_n = 1;
    applyStimulus(2'b10, 32'h20, 32'd5, 32'd7, 1'b0);
    tick();
    checkOutput("post_reset_add", exm_alu_result, 32'd12);
    checkOutput("post_reset_valid", 32'(exm_valid), 32'd1);
    checkOutput("post_reset_busy", 32'(ex_busy), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage: the consumer of the ID/EX pipeline latch.
- Decodes the ALU operation from alu_op and funct, and executes it.
- Resolves branch and jump targets.
- Registers results into the EX/MEM boundary.
- MULT executes on an iterative shift-add sub-unit; ex_busy holds the upstream latch while it runs.

Parameters:
- XLEN, 32, datapath width.
- MUL_CYCLES, 32, shift-add iterations; must equal XLEN.

Ports:
- clock  in  1  single clock; rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  ID/EX bundle holds a real instruction.
- branch, jump, alu_src, mem_read, mem_write, reg_write, reg_dst, mem_to_reg  in  1 each  control bits from ID/EX.
- alu_op  in  2  00 add, 01 sub, 10 use funct, 11 or.
- npc, readdata1, readdata2, sigext  in  XLEN each  ID/EX data.
- rt, rd  in  5 each  instruction fields 20:16 and 15:11.
- mem_stall  in  1  EX/MEM must hold.
- ex_busy  out  1  ID/EX must hold its contents.
- exm_valid, exm_mem_read, exm_mem_write, exm_reg_write, exm_mem_to_reg  out  1 each  registered.
- exm_alu_result, exm_write_data  out  XLEN each  registered.
- exm_write_reg  out  5  registered.
- exm_flush  out  1  registered redirect; branch taken or jump.
- exm_target  out  XLEN  registered redirect PC.

Behaviour:
- Reset: every exm_* output is 0; state IDLE; counter 0; ex_busy 0.
- A reset during MUL or DONE aborts the operation; no partial result is committed.
- Operand B is sigext when alu_src=1, otherwise readdata2.
- funct is sigext[5:0] when alu_op=10:
  - 100000 add
  - 100010 sub
  - 100100 and
  - 100101 or
  - 101010 slt (signed, result 0 or 1)
  - 000000 sll, B << sigext[10:6]
  - 011000 mult (low XLEN bits of the product)
  - any other funct gives result 0.
- Arithmetic wraps modulo 2^XLEN; no overflow trap.
- exm_write_reg = reg_dst ? rd : rt.
- exm_write_data = readdata2.
- Branch:
  - taken = branch & ex_valid & (readdata1 == readdata2).
  - exm_target = npc + (sigext << 2).
- Jump:
  - exm_target = {npc[31:28], sigext[25:0], 2'b00}.
  - Jump takes priority over branch.
- exm_flush = taken | (jump & ex_valid).
- State machine: IDLE, MUL, DONE.
  - IDLE, mem_stall=1: all exm_* hold.
  - IDLE, non-MULT: at each edge the exm_* outputs load the current bundle; latency 1 cycle. exm_valid = ex_valid. If ex_valid=0, all exm control bits load 0.
  - IDLE, ex_valid & MULT & !mem_stall: latch both operands; counter=0; go to MUL; exm_valid loads 0 (bubble).
  - MUL: one iteration per cycle; counter increments. After iteration MUL_CYCLES-1, go to DONE. mem_stall does not pause iterations.
  - DONE, !mem_stall: commit product and latched controls with exm_valid=1; go to IDLE.
  - DONE, mem_stall: hold in DONE.
- Commit timing: with no stall, an uncontended MULT accepted at edge 0 commits at edge MUL_CYCLES+1.
- ex_busy = (state != IDLE) | mem_stall. This is combinational from state and mem_stall.
- Upstream must keep ID/EX stable while ex_busy=1. The block does not depend on this for MULT operands, which are latched.

Decomposition:
- Package ex_pkg:
  - alu_op encodings.
  - funct constants.
  - ALU-control enum (ADD, SUB, AND, OR, SLT, SLL, MUL, NOP).
  - state enum (IDLE, MUL, DONE).
  - XLEN default.
- Sub-module ex_mult_seq:
  - Iterative shift-add multiplier with start, operands, done and product.
  - Owns the counter.
  - ex_stage owns the state machine and the EX/MEM registers.

Test Plan:
- add: alu_op=10, funct 100000, readdata1=5, readdata2=7, ex_valid=1 -> next edge exm_alu_result=12, exm_valid=1, exm_write_reg=rd when reg_dst=1.
- Signed slt and immediate add: slt with readdata1=0xFFFFFFFF, readdata2=1 -> result 1. alu_op=00, alu_src=1, sigext=0xFFFFFFFC, readdata1=8 -> result 4.
- beq: branch=1, readdata1=readdata2=3, npc=0x100, sigext=4 -> exm_flush=1, exm_target=0x110. Same bundle with readdata2=4 -> exm_flush=0.
- mult: operands 7 and 6 -> ex_busy high for 33 cycles; exm_valid=0 until edge 33; then exm_alu_result=42 and exm_valid=1 for one cycle.
- mult with mem_stall asserted in DONE for 3 cycles -> commit is delayed 3 cycles; product stays 42; ex_busy stays high throughout.
- reset_n low mid-MUL (cycle 10) -> all exm_* are 0 immediately and asynchronously; after release the state is IDLE and a new add completes in 1 cycle.
